ysyx_22050243_trap_csr_ctrl: RTL and testbench
==============================================

# ysyx_22050243_trap_csr_ctrl

Write-back-stage trap controller and machine-mode trap CSR file. It consumes the trap decision from the WB exception detector (`excep_csr_update`, `mret_csr_update`) and atomically updates `mstatus`, `mepc` and `mcause`. It then issues a PC redirect to fetch through a valid/ready handshake. It owns `mstatus`, `mie`, `mtvec`, `mepc` and `mcause`, and feeds `mstatus` and `mie` back to the detector.

## Interface
Parameters:
- `ADDR_WIDTH`, 12, CSR address width.
- `DBUS_DATA_WIDTH`, 64, XLEN; width of CSRs and PCs.

Ports:
- `clk`  in  1  the single clock.
- `rst_n`  in  1  reset. Asynchronous assert, active-low.
- `wb_valid`  in  1  the WB instruction is valid this cycle.
- `excep_csr_update`  in  2  trap request: 01 = ecall, 10 = timer IRQ, 00 = none.
- `mret_csr_update`  in  1  the WB instruction is an mret.
- `wb_pc`  in  64  PC of the WB instruction.
- `wb_next_pc`  in  64  PC of the next instruction to execute.
- `csr_wen`  in  1  CSR write from a WB csrr* instruction.
- `csr_addr`  in  12  CSR address for the write and read ports.
- `csr_wdata`  in  64  CSR write data, already merged for set/clear.
- `csr_rdata`  out  64  combinational read of `csr_addr`; 0 for unimplemented addresses.
- `mstatus`  out  64  current `mstatus`, to the detector.
- `mie`  out  64  current `mie`, to the detector.
- `redirect_valid`  out  1  a redirect PC is pending.
- `redirect_pc`  out  64  redirect target.
- `redirect_ready`  in  1  fetch accepts the redirect.
- `trap_busy`  out  1  high whenever the FSM is not IDLE. Used as flush/stall for the upstream stages.

## Operation
FSM states: IDLE, REDIRECT.

IDLE, evaluated in priority order:
- `wb_valid` and `excep_csr_update`=01 (ecall):
  - `mepc`<=`wb_pc`, `mcause`<=64'd11.
  - Trap `mstatus` update (below).
  - `redirect_pc`<=`mtvec` base, go to REDIRECT.
- `excep_csr_update`=10 (timer), independent of `wb_valid`:
  - `mepc`<=`wb_next_pc`, `mcause`<={1'b1, 63'd7}.
  - Trap `mstatus` update (below).
  - `redirect_pc`<=vector target, go to REDIRECT.
- `wb_valid` and `mret_csr_update`:
  - `mstatus`.MIE<=MPIE, MPIE<=1, MPP<=2'b11.
  - `redirect_pc`<=`mepc`, go to REDIRECT.
- Otherwise: `csr_wen` writes the addressed CSR.
  - `mepc`[1:0] is forced to 0.
  - `mstatus` writes affect only MIE[3], MPIE[7] and MPP[12:11]; MPP is always 2'b11.
  - Writes to other addresses are ignored.

Trap `mstatus` update (ecall and timer): MPIE<=MIE, MIE<=0, MPP<=2'b11.

REDIRECT:
- Hold `redirect_valid`=1 and a stable `redirect_pc`.
- Return to IDLE on the cycle where `redirect_ready`=1.
- All trap, mret and `csr_wen` inputs are ignored.

Vector target: `mtvec` & ~64'h3.

Boundary cases:
- ecall together with timer: ecall wins. The timer request stays pending and is serviced after MIE is restored.
- Trap together with `csr_wen`: the trap wins and the CSR write is dropped.
- `mret_csr_update` with a trap code: the trap wins.
- Reset asserted mid-REDIRECT: FSM returns to IDLE immediately and `redirect_valid` drops asynchronously.

## Timing
- Trap or mret accepted in cycle T:
  - All CSR updates become visible at edge T+1.
  - `redirect_valid` and `trap_busy` are high from T+1.
- Minimum of 1 cycle in REDIRECT; the FSM leaves on the edge after `redirect_ready` is sampled high.
- `csr_rdata` is combinational. A write in cycle T is visible from T+1.
- `mstatus` and `mie` outputs are registered, so the detector sees the cleared MIE from T+1. This blocks a re-trap.
- Reset values:
  - `mstatus`=64'h1800.
  - `mie`, `mtvec`, `mepc`, `mcause`=0.
  - `redirect_pc`=0, `redirect_valid`=0, `trap_busy`=0, state IDLE.

## Configuration
`YSYX_22050243_VECTORED_MTVEC_EN`:
- Defined: when `mtvec`[1:0]=01, an interrupt redirects to base+4*cause[62:0]. A timer interrupt therefore goes to base+0x1C. Exceptions always go to base.
- Undefined: all traps go to base. `mtvec`[1:0] is forced to 00 on write.

## Structure
- Package `ysyx_22050243_csr_pkg`:
  - CSR addresses: MSTATUS 12'h300, MIE 12'h304, MTVEC 12'h305, MEPC 12'h341, MCAUSE 12'h342.
  - `mstatus` bit indices MIE=3, MPIE=7, MPP=12:11.
  - Cause constants: ECALL_M=11, IRQ_MTIMER=7.
  - Two-state FSM enum.
- Sub-module `ysyx_22050243_mstatus_reg`: holds `mstatus`; handles the trap-entry, mret and CSR-write update paths with trap priority.

## Test plan
- Reset with `mtvec`=0 → release reset → `mstatus`=64'h1800, `redirect_valid`=0, `csr_rdata`@0x300=64'h1800.
- Ecall:
  - Stimulus: write `mtvec`=64'h8000_0100, set MIE; then ecall at `wb_pc`=64'h8000_0040.
  - Response: next cycle `mepc`=64'h8000_0040, `mcause`=11, MIE=0, MPIE=1, `redirect_pc`=64'h8000_0100.
  - Hold `redirect_ready` low for 3 cycles → `redirect_valid` stays high for 3 cycles.
- Timer IRQ with `mtvec`=64'h8000_0101 and `wb_next_pc`=64'h8000_0044:
  - `mcause`=64'h8000_0000_0000_0007, `mepc`=64'h8000_0044.
  - `redirect_pc`=64'h8000_011C with the macro defined, 64'h8000_0100 without.
- Mret after the ecall case → MIE=1, MPIE=1, `redirect_pc`=`mepc`.
- Simultaneous ecall, timer and `csr_wen` to `mtvec`:
  - ecall cause 11 taken and `mtvec` unchanged.
  - After mret restores MIE, the timer is taken.
- Assert `rst_n` low while in REDIRECT → `redirect_valid` drops with no clock edge; state is IDLE after release.

Source files
------------

// File: rtl/ysyx_22050243_trap_csr_ctrl_pkg.sv
// Shared CSR addresses, mstatus field positions, trap causes and FSM states
// for the machine-mode trap controller.
package ysyx_22050243_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int CAUSE_ECALL_M    = 11;
    localparam int CAUSE_IRQ_MTIMER = 7;

    typedef enum logic {
        ST_IDLE,
        ST_REDIRECT
    } trap_state_e;

endpackage

// File: rtl/ysyx_22050243_trap_csr_ctrl_if.sv
// WB-stage trap/CSR bundle: the pipeline side is master, the trap controller is slave.
interface ysyx_22050243_trap_csr_ctrl_if #(
    parameter int ADDR_WIDTH      = 12,
    parameter int DBUS_DATA_WIDTH = 64
);
    logic                       wb_valid;
    logic [1:0]                 excep_csr_update;
    logic                       mret_csr_update;
    logic [DBUS_DATA_WIDTH-1:0] wb_pc;
    logic [DBUS_DATA_WIDTH-1:0] wb_next_pc;
    logic                       csr_wen;
    logic [ADDR_WIDTH-1:0]      csr_addr;
    logic [DBUS_DATA_WIDTH-1:0] csr_wdata;
    logic [DBUS_DATA_WIDTH-1:0] csr_rdata;
    logic [DBUS_DATA_WIDTH-1:0] mstatus;
    logic [DBUS_DATA_WIDTH-1:0] mie;
    logic                       redirect_valid;
    logic [DBUS_DATA_WIDTH-1:0] redirect_pc;
    logic                       redirect_ready;
    logic                       trap_busy;

    modport master (
        output wb_valid, excep_csr_update, mret_csr_update, wb_pc, wb_next_pc,
               csr_wen, csr_addr, csr_wdata, redirect_ready,
        input  csr_rdata, mstatus, mie, redirect_valid, redirect_pc, trap_busy
    );

    modport slave (
        input  wb_valid, excep_csr_update, mret_csr_update, wb_pc, wb_next_pc,
               csr_wen, csr_addr, csr_wdata, redirect_ready,
        output csr_rdata, mstatus, mie, redirect_valid, redirect_pc, trap_busy
    );
endinterface

// File: rtl/ysyx_22050243_trap_csr_ctrl_mstatus_reg.sv
// mstatus holder: only MIE/MPIE are state, MPP is hard-wired to machine mode.
// Update priority is trap entry, then mret, then CSR write.
module ysyx_22050243_mstatus_reg
    import ysyx_22050243_csr_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            trap_i,
    input  logic            mret_i,
    input  logic            wen_i,
    input  logic            wmie_i,
    input  logic            wmpie_i,
    output logic [XLEN-1:0] mstatus_o
);
    logic mie_q, mie_d;
    logic mpie_q, mpie_d;

    // NOTE: hold-value defaults first so no path through this block infers a latch.
    always_comb begin
        mie_d  = mie_q;
        mpie_d = mpie_q;
        if (trap_i) begin
            mpie_d = mie_q;
            mie_d  = 1'b0;
        end else if (mret_i) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (wen_i) begin
            mie_d  = wmie_i;
            mpie_d = wmpie_i;
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q  <= 1'b0;
            mpie_q <= 1'b0;
        end else begin
            mie_q  <= mie_d;
            mpie_q <= mpie_d;
        end
    end

    always_comb begin
        mstatus_o                                = '0;
        mstatus_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus_o[MSTATUS_MPIE]                  = mpie_q;
        mstatus_o[MSTATUS_MIE]                   = mie_q;
    end
endmodule

// File: rtl/ysyx_22050243_trap_csr_ctrl.sv
// WB-stage trap controller and M-mode trap CSR file with a valid/ready PC redirect.
// Optional YSYX_22050243_VECTORED_MTVEC_EN enables vectored interrupt targets.
module ysyx_22050243_trap_csr_ctrl
    import ysyx_22050243_csr_pkg::*;
#(
    parameter int ADDR_WIDTH      = 12,
    parameter int DBUS_DATA_WIDTH = 64
) (
    input logic                          clk,
    input logic                          rst_n,
    ysyx_22050243_trap_csr_ctrl_if.slave bus_if
);
    localparam int XLEN = DBUS_DATA_WIDTH;
    localparam logic [XLEN-1:0] ECALL_CAUSE = XLEN'(CAUSE_ECALL_M);
    localparam logic [XLEN-1:0] IRQ_CAUSE   = {1'b1, (XLEN-1)'(CAUSE_IRQ_MTIMER)};

    trap_state_e     state_q;
    logic [XLEN-1:0] mie_q, mtvec_q, mepc_q, mcause_q, redirect_pc_q;
    logic [XLEN-1:0] mstatus;
    logic [XLEN-1:0] vec_base, irq_target;
    logic            idle, ecall, timer, take_trap, mret, csr_wr;

    // excep_csr_update is decoded per bit so that 2'b11 (ecall + timer) resolves to ecall.
    assign idle      = (state_q == ST_IDLE);
    assign ecall     = idle & bus_if.wb_valid & bus_if.excep_csr_update[0];
    assign timer     = idle & ~ecall & bus_if.excep_csr_update[1];
    assign take_trap = ecall | timer;
    assign mret      = idle & ~take_trap & bus_if.wb_valid & bus_if.mret_csr_update;
    assign csr_wr    = idle & ~take_trap & ~mret & bus_if.csr_wen;

    assign vec_base = {mtvec_q[XLEN-1:2], 2'b00};
`ifdef YSYX_22050243_VECTORED_MTVEC_EN
    assign irq_target = (mtvec_q[1:0] == 2'b01) ? vec_base + {IRQ_CAUSE[XLEN-3:0], 2'b00}
                                                : vec_base;
`else
    assign irq_target = vec_base;
`endif

    ysyx_22050243_mstatus_reg #(.XLEN(XLEN)) u_mstatus (
        .clk      (clk),
        .rst_n    (rst_n),
        .trap_i   (take_trap),
        .mret_i   (mret),
        .wen_i    (csr_wr && (bus_if.csr_addr == ADDR_WIDTH'(CSR_MSTATUS))),
        .wmie_i   (bus_if.csr_wdata[MSTATUS_MIE]),
        .wmpie_i  (bus_if.csr_wdata[MSTATUS_MPIE]),
        .mstatus_o(mstatus)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            mie_q         <= '0;
            mtvec_q       <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            redirect_pc_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ecall) begin
                        mepc_q        <= bus_if.wb_pc;
                        mcause_q      <= ECALL_CAUSE;
                        redirect_pc_q <= vec_base;
                        state_q       <= ST_REDIRECT;
                    end else if (timer) begin
                        mepc_q        <= bus_if.wb_next_pc;
                        mcause_q      <= IRQ_CAUSE;
                        redirect_pc_q <= irq_target;
                        state_q       <= ST_REDIRECT;
                    end else if (mret) begin
                        redirect_pc_q <= mepc_q;
                        state_q       <= ST_REDIRECT;
                    end else if (csr_wr) begin
                        case (bus_if.csr_addr)
                            ADDR_WIDTH'(CSR_MIE):    mie_q    <= bus_if.csr_wdata;
`ifdef YSYX_22050243_VECTORED_MTVEC_EN
                            ADDR_WIDTH'(CSR_MTVEC):  mtvec_q  <= bus_if.csr_wdata;
`else
                            ADDR_WIDTH'(CSR_MTVEC):  mtvec_q  <= {bus_if.csr_wdata[XLEN-1:2], 2'b00};
`endif
                            ADDR_WIDTH'(CSR_MEPC):   mepc_q   <= {bus_if.csr_wdata[XLEN-1:2], 2'b00};
                            ADDR_WIDTH'(CSR_MCAUSE): mcause_q <= bus_if.csr_wdata;
                            default: ;
                        endcase
                    end
                end
                ST_REDIRECT: begin
                    if (bus_if.redirect_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus_if.csr_rdata = '0;
        case (bus_if.csr_addr)
            ADDR_WIDTH'(CSR_MSTATUS): bus_if.csr_rdata = mstatus;
            ADDR_WIDTH'(CSR_MIE):     bus_if.csr_rdata = mie_q;
            ADDR_WIDTH'(CSR_MTVEC):   bus_if.csr_rdata = mtvec_q;
            ADDR_WIDTH'(CSR_MEPC):    bus_if.csr_rdata = mepc_q;
            ADDR_WIDTH'(CSR_MCAUSE):  bus_if.csr_rdata = mcause_q;
            default: ;
        endcase
    end

    // Redirect handshake comes straight off the state flop, so reset drops it asynchronously.
    assign bus_if.mstatus        = mstatus;
    assign bus_if.mie            = mie_q;
    assign bus_if.redirect_valid = (state_q == ST_REDIRECT);
    assign bus_if.trap_busy      = (state_q == ST_REDIRECT);
    assign bus_if.redirect_pc    = redirect_pc_q;
endmodule

// File: tb/tb_ysyx_22050243_trap_csr_ctrl.sv
// Directed self-checking bench for the WB trap controller and trap CSR file.
module tb_ysyx_22050243_trap_csr_ctrl;
    import ysyx_22050243_csr_pkg::*;

`ifdef YSYX_22050243_VECTORED_MTVEC_EN
    localparam logic [63:0] EXP_MTVEC_VEC = 64'h8000_0101;
    localparam logic [63:0] EXP_IRQ_PC    = 64'h8000_011C;
`else
    localparam logic [63:0] EXP_MTVEC_VEC = 64'h8000_0100;
    localparam logic [63:0] EXP_IRQ_PC    = 64'h8000_0100;
`endif
    localparam logic [63:0] IRQ_CAUSE = 64'h8000_0000_0000_0007;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run = 0;
    int   tests_failed = 0;

    ysyx_22050243_trap_csr_ctrl_if #(.ADDR_WIDTH(12), .DBUS_DATA_WIDTH(64)) bus_if ();

    ysyx_22050243_trap_csr_ctrl #(.ADDR_WIDTH(12), .DBUS_DATA_WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_if(bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.wb_valid         = 1'b0;
        bus_if.excep_csr_update = 2'b00;
        bus_if.mret_csr_update  = 1'b0;
        bus_if.csr_wen          = 1'b0;
        bus_if.redirect_ready   = 1'b0;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [63:0] data);
        bus_if.csr_wen   = 1'b1;
        bus_if.csr_addr  = addr;
        bus_if.csr_wdata = data;
        tick();
        bus_if.csr_wen   = 1'b0;
    endtask

    task automatic csr_read(input logic [11:0] addr, output logic [63:0] data);
        bus_if.csr_addr = addr;
        #1;
        data = bus_if.csr_rdata;
    endtask

    task automatic accept_redirect();
        bus_if.redirect_ready = 1'b1;
        tick();
        bus_if.redirect_ready = 1'b0;
    endtask

    task automatic do_mret();
        bus_if.wb_valid        = 1'b1;
        bus_if.mret_csr_update = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        logic [63:0] rd;
        rst_n = 1'b1;
        clear_inputs();
        bus_if.wb_pc = '0; bus_if.wb_next_pc = '0; bus_if.csr_addr = '0; bus_if.csr_wdata = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        tests_run++; if (bus_if.mstatus !== 64'h1800) begin tests_failed++; $display("FAIL reset_mstatus: got %h want %h", bus_if.mstatus, 64'h1800); end
        tests_run++; if (bus_if.redirect_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_redirect_valid: got %b want 0", bus_if.redirect_valid); end
        tests_run++; if (bus_if.trap_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_trap_busy: got %b want 0", bus_if.trap_busy); end
        tests_run++; if (bus_if.redirect_pc !== 64'h0) begin tests_failed++; $display("FAIL reset_redirect_pc: got %h want 0", bus_if.redirect_pc); end
        csr_read(CSR_MSTATUS, rd);
        tests_run++; if (rd !== 64'h1800) begin tests_failed++; $display("FAIL reset_rdata_mstatus: got %h want %h", rd, 64'h1800); end
        csr_read(CSR_MTVEC, rd);
        tests_run++; if (rd !== 64'h0) begin tests_failed++; $display("FAIL reset_rdata_mtvec: got %h want 0", rd); end
        csr_read(12'h123, rd);
        tests_run++; if (rd !== 64'h0) begin tests_failed++; $display("FAIL unimpl_rdata: got %h want 0", rd); end
    endtask

    task automatic test_csr_write();
        logic [63:0] rd;
        csr_write(CSR_MSTATUS, 64'hFFFF_FFFF_FFFF_FFFF);
        csr_read(CSR_MSTATUS, rd);
        tests_run++; if (rd !== 64'h1888) begin tests_failed++; $display("FAIL mstatus_write_mask: got %h want %h", rd, 64'h1888); end
        csr_write(CSR_MSTATUS, 64'h0);
        tests_run++; if (bus_if.mstatus !== 64'h1800) begin tests_failed++; $display("FAIL mstatus_write_clear: got %h want %h", bus_if.mstatus, 64'h1800); end
        csr_write(CSR_MEPC, 64'h8000_0043);
        csr_read(CSR_MEPC, rd);
        tests_run++; if (rd !== 64'h8000_0040) begin tests_failed++; $display("FAIL mepc_align: got %h want %h", rd, 64'h8000_0040); end
        csr_write(CSR_MIE, 64'h80);
        tests_run++; if (bus_if.mie !== 64'h80) begin tests_failed++; $display("FAIL mie_write: got %h want %h", bus_if.mie, 64'h80); end
        csr_write(CSR_MCAUSE, 64'h5);
        csr_read(CSR_MCAUSE, rd);
        tests_run++; if (rd !== 64'h5) begin tests_failed++; $display("FAIL mcause_write: got %h want 5", rd); end
    endtask

    task automatic test_ecall();
        logic [63:0] rd;
        csr_write(CSR_MTVEC, 64'h8000_0100);
        csr_write(CSR_MSTATUS, 64'h8);
        bus_if.wb_valid = 1'b1; bus_if.excep_csr_update = 2'b01; bus_if.wb_pc = 64'h8000_0040;
        tick();
        clear_inputs();
        tests_run++; if (bus_if.redirect_valid !== 1'b1 || bus_if.trap_busy !== 1'b1) begin tests_failed++; $display("FAIL ecall_valid_busy: got %b%b want 11", bus_if.redirect_valid, bus_if.trap_busy); end
        tests_run++; if (bus_if.redirect_pc !== 64'h8000_0100) begin tests_failed++; $display("FAIL ecall_redirect_pc: got %h want %h", bus_if.redirect_pc, 64'h8000_0100); end
        tests_run++; if (bus_if.mstatus !== 64'h1880) begin tests_failed++; $display("FAIL ecall_mstatus: got %h want %h", bus_if.mstatus, 64'h1880); end
        csr_read(CSR_MEPC, rd);
        tests_run++; if (rd !== 64'h8000_0040) begin tests_failed++; $display("FAIL ecall_mepc: got %h want %h", rd, 64'h8000_0040); end
        csr_read(CSR_MCAUSE, rd);
        tests_run++; if (rd !== 64'd11) begin tests_failed++; $display("FAIL ecall_mcause: got %h want %h", rd, 64'd11); end
        // A CSR write issued during REDIRECT must be dropped.
        bus_if.csr_wen = 1'b1; bus_if.csr_addr = CSR_MTVEC; bus_if.csr_wdata = 64'hDEAD_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if (bus_if.redirect_valid !== 1'b1 || bus_if.redirect_pc !== 64'h8000_0100) begin tests_failed++; $display("FAIL ecall_hold_%0d: got valid %b pc %h want 1 %h", i, bus_if.redirect_valid, bus_if.redirect_pc, 64'h8000_0100); end
        end
        bus_if.csr_wen = 1'b0;
        accept_redirect();
        tests_run++; if (bus_if.redirect_valid !== 1'b0 || bus_if.trap_busy !== 1'b0) begin tests_failed++; $display("FAIL ecall_release: got %b%b want 00", bus_if.redirect_valid, bus_if.trap_busy); end
        csr_read(CSR_MTVEC, rd);
        tests_run++; if (rd !== 64'h8000_0100) begin tests_failed++; $display("FAIL redirect_drops_wen: got %h want %h", rd, 64'h8000_0100); end
    endtask

    task automatic test_mret();
        do_mret();
        tests_run++; if (bus_if.mstatus !== 64'h1888) begin tests_failed++; $display("FAIL mret_mstatus: got %h want %h", bus_if.mstatus, 64'h1888); end
        tests_run++; if (bus_if.redirect_valid !== 1'b1 || bus_if.redirect_pc !== 64'h8000_0040) begin tests_failed++; $display("FAIL mret_redirect: got %b %h want 1 %h", bus_if.redirect_valid, bus_if.redirect_pc, 64'h8000_0040); end
        accept_redirect();
    endtask

    task automatic test_timer();
        logic [63:0] rd;
        csr_write(CSR_MTVEC, 64'h8000_0101);
        csr_read(CSR_MTVEC, rd);
        tests_run++; if (rd !== EXP_MTVEC_VEC) begin tests_failed++; $display("FAIL mtvec_mode_bits: got %h want %h", rd, EXP_MTVEC_VEC); end
        bus_if.wb_valid = 1'b0; bus_if.excep_csr_update = 2'b10; bus_if.wb_next_pc = 64'h8000_0044;
        tick();
        clear_inputs();
        tests_run++; if (bus_if.redirect_pc !== EXP_IRQ_PC) begin tests_failed++; $display("FAIL timer_redirect_pc: got %h want %h", bus_if.redirect_pc, EXP_IRQ_PC); end
        tests_run++; if (bus_if.mstatus !== 64'h1880) begin tests_failed++; $display("FAIL timer_mstatus: got %h want %h", bus_if.mstatus, 64'h1880); end
        csr_read(CSR_MCAUSE, rd);
        tests_run++; if (rd !== IRQ_CAUSE) begin tests_failed++; $display("FAIL timer_mcause: got %h want %h", rd, IRQ_CAUSE); end
        csr_read(CSR_MEPC, rd);
        tests_run++; if (rd !== 64'h8000_0044) begin tests_failed++; $display("FAIL timer_mepc: got %h want %h", rd, 64'h8000_0044); end
        accept_redirect();
        do_mret();
        tests_run++; if (bus_if.redirect_pc !== 64'h8000_0044 || bus_if.mstatus !== 64'h1888) begin tests_failed++; $display("FAIL timer_mret: got %h %h want %h %h", bus_if.redirect_pc, bus_if.mstatus, 64'h8000_0044, 64'h1888); end
        accept_redirect();
    endtask

    task automatic test_simultaneous();
        logic [63:0] rd;
        bus_if.wb_valid = 1'b1; bus_if.excep_csr_update = 2'b11; bus_if.mret_csr_update = 1'b1;
        bus_if.wb_pc = 64'h8000_0080; bus_if.wb_next_pc = 64'h8000_0084;
        bus_if.csr_wen = 1'b1; bus_if.csr_addr = CSR_MTVEC; bus_if.csr_wdata = 64'h0000_1234_0000_0000;
        tick();
        clear_inputs();
        bus_if.excep_csr_update = 2'b10;
        csr_read(CSR_MCAUSE, rd);
        tests_run++; if (rd !== 64'd11) begin tests_failed++; $display("FAIL simul_mcause: got %h want %h", rd, 64'd11); end
        csr_read(CSR_MEPC, rd);
        tests_run++; if (rd !== 64'h8000_0080) begin tests_failed++; $display("FAIL simul_mepc: got %h want %h", rd, 64'h8000_0080); end
        csr_read(CSR_MTVEC, rd);
        tests_run++; if (rd !== EXP_MTVEC_VEC) begin tests_failed++; $display("FAIL simul_mtvec_kept: got %h want %h", rd, EXP_MTVEC_VEC); end
        tests_run++; if (bus_if.redirect_pc !== 64'h8000_0100) begin tests_failed++; $display("FAIL simul_redirect_pc: got %h want %h", bus_if.redirect_pc, 64'h8000_0100); end
        tick();
        csr_read(CSR_MCAUSE, rd);
        tests_run++; if (rd !== 64'd11 || bus_if.redirect_valid !== 1'b1) begin tests_failed++; $display("FAIL simul_timer_ignored: got %h %b want %h 1", rd, bus_if.redirect_valid, 64'd11); end
        // MIE is now 0, so the detector masks the pending timer until mret.
        bus_if.excep_csr_update = 2'b00;
        accept_redirect();
        do_mret();
        tests_run++; if (bus_if.mstatus !== 64'h1888 || bus_if.redirect_pc !== 64'h8000_0080) begin tests_failed++; $display("FAIL simul_mret: got %h %h want %h %h", bus_if.mstatus, bus_if.redirect_pc, 64'h1888, 64'h8000_0080); end
        accept_redirect();
        bus_if.excep_csr_update = 2'b10; bus_if.wb_next_pc = 64'h8000_0088;
        tick();
        clear_inputs();
        csr_read(CSR_MCAUSE, rd);
        tests_run++; if (rd !== IRQ_CAUSE) begin tests_failed++; $display("FAIL pending_timer_mcause: got %h want %h", rd, IRQ_CAUSE); end
        csr_read(CSR_MEPC, rd);
        tests_run++; if (rd !== 64'h8000_0088) begin tests_failed++; $display("FAIL pending_timer_mepc: got %h want %h", rd, 64'h8000_0088); end
        accept_redirect();
    endtask

    task automatic test_reset_in_redirect();
        logic [63:0] rd;
        bus_if.wb_valid = 1'b1; bus_if.excep_csr_update = 2'b01; bus_if.wb_pc = 64'h8000_00C0;
        tick();
        clear_inputs();
        tests_run++; if (bus_if.redirect_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_valid: got %b want 1", bus_if.redirect_valid); end
        #1 rst_n = 1'b0;
        #1;
        tests_run++; if (bus_if.redirect_valid !== 1'b0 || bus_if.trap_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_async_drop: got %b%b want 00", bus_if.redirect_valid, bus_if.trap_busy); end
        @(negedge clk) rst_n = 1'b1;
        tick();
        tests_run++; if (bus_if.redirect_valid !== 1'b0 || bus_if.mstatus !== 64'h1800) begin tests_failed++; $display("FAIL rst_post_idle: got %b %h want 0 %h", bus_if.redirect_valid, bus_if.mstatus, 64'h1800); end
        csr_read(CSR_MTVEC, rd);
        tests_run++; if (rd !== 64'h0) begin tests_failed++; $display("FAIL rst_post_mtvec: got %h want 0", rd); end
    endtask

    initial begin
        test_reset();
        test_csr_write();
        test_ecall();
        test_mret();
        test_timer();
        test_simultaneous();
        test_reset_in_redirect();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
